// File: rtl/fir_job_ctrl.sv
// Sequences one FIR job: tap/ntaps commit, L-sample stream, M-1 zero flush, result count.
// Define FIR_JOB_CTRL_TIMEOUT_EN to enable the DRAIN watchdog and the o_err flag.
module fir_job_ctrl #(
   parameter int unsigned NTAPS = 8,
   parameter int unsigned IW    = 12,
   parameter int unsigned TW    = 12,
   parameter int unsigned LW    = 16,
   parameter int unsigned AW    = 3
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic [3:0]          i_ntaps,
   input  logic [LW-1:0]       i_len,
   input  logic                i_tap_we,
   input  logic [AW-1:0]       i_tap_addr,
   input  logic [TW-1:0]       i_tap_wdata,
   input  logic                i_s_valid,
   input  logic [IW-1:0]       i_s_data,
   output logic                o_s_ready,
   output logic                o_fir_ce,
   output logic [IW-1:0]       o_fir_sample,
   output logic [NTAPS*TW-1:0] o_fir_taps,
   output logic                o_fir_tap_wr,
   output logic [3:0]          o_fir_ntaps,
   output logic                o_fir_ntaps_en,
   input  logic                i_fir_valid,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err
);

   typedef enum logic [2:0] {StIdle, StConfig, StStream, StFlush, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [LW-1:0]   len_q, len_d, in_cnt_q, in_cnt_d;
   logic [3:0]      m_q, m_d, flush_cnt_q, flush_cnt_d;
   logic [LW:0]     res_cnt_q, res_cnt_d, res_next, target;
   logic            ce_q, ce_d;
   logic [IW-1:0]   sample_q, sample_d;
   logic [TW-1:0]   taps_q [NTAPS];
   logic            hs, last_in, counting, res_inc, res_hit, tap_wr_en, timeout;

   assign hs        = (state_q == StStream) && i_s_valid;
   assign last_in   = (in_cnt_q + LW'(1)) == len_q;
   assign counting  = (state_q == StStream) || (state_q == StFlush) || (state_q == StDrain);
   assign target    = {1'b0, len_q} + (LW+1)'(m_q) - (LW+1)'(1);
   // Saturate at the target so surplus result strobes are ignored
   assign res_inc   = counting && i_fir_valid && (res_cnt_q != target);
   assign res_next  = res_cnt_q + (LW+1)'(res_inc);
   assign res_hit   = res_next == target;
   assign tap_wr_en = i_tap_we && (state_q == StIdle) && (32'(i_tap_addr) < NTAPS);

`ifdef FIR_JOB_CTRL_TIMEOUT_EN
   localparam logic [9:0] WdLimit = 10'd1021;
   logic [9:0] wd_q, wd_d;
   logic       err_q;

   // wd_q is the number of idle cycles since the last strobe, minus one
   always_comb begin
      wd_d = '0;
      if (counting && !i_fir_valid && wd_q != 10'h3ff) begin
         wd_d = wd_q + 10'd1;
      end
   end

   assign timeout = (state_q == StDrain) && !res_hit && !i_fir_valid && (wd_q >= WdLimit);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q <= wd_d;
         if (state_q == StIdle && i_start && !i_abort) begin
            err_q <= 1'b0;
         end else if (timeout && !i_abort) begin
            err_q <= 1'b1;
         end
      end
   end

   assign o_err = err_q;
`else
   assign timeout = 1'b0;
   assign o_err   = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      m_d         = m_q;
      in_cnt_d    = in_cnt_q;
      flush_cnt_d = flush_cnt_q;
      res_cnt_d   = res_next;
      ce_d        = 1'b0;
      sample_d    = '0;
      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               len_d       = i_len;
               if (i_ntaps == 4'd0) begin
                  m_d = 4'd1;
               end else if (32'(i_ntaps) > NTAPS) begin
                  m_d = 4'(NTAPS);
               end else begin
                  m_d = i_ntaps;
               end
               in_cnt_d    = '0;
               flush_cnt_d = '0;
               res_cnt_d   = '0;
               state_d     = StConfig;
            end
         end
         StConfig: state_d = (len_q == '0) ? StDone : StStream;
         StStream: begin
            if (hs) begin
               ce_d     = 1'b1;
               sample_d = i_s_data;
               in_cnt_d = in_cnt_q + LW'(1);
               if (last_in) begin
                  if (m_q == 4'd1) begin
                     state_d = res_hit ? StDone : StDrain;
                  end else begin
                     state_d = StFlush;
                  end
               end
            end
         end
         StFlush: begin
            ce_d        = 1'b1;
            flush_cnt_d = flush_cnt_q + 4'd1;
            if (flush_cnt_d == m_q - 4'd1) begin
               state_d = res_hit ? StDone : StDrain;
            end
         end
         StDrain: begin
            if (res_hit || timeout) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (i_abort && state_q != StIdle) begin
         state_d  = StIdle;
         ce_d     = 1'b0;
         sample_d = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= StIdle;
         len_q       <= '0;
         m_q         <= 4'(NTAPS);
         in_cnt_q    <= '0;
         flush_cnt_q <= '0;
         res_cnt_q   <= '0;
         ce_q        <= 1'b0;
         sample_q    <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         m_q         <= m_d;
         in_cnt_q    <= in_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         res_cnt_q   <= res_cnt_d;
         ce_q        <= ce_d;
         sample_q    <= sample_d;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int unsigned k = 0; k < NTAPS; k++) begin
            taps_q[k] <= '0;
         end
      end else if (tap_wr_en) begin
         taps_q[i_tap_addr] <= i_tap_wdata;
      end
   end

   for (genvar g = 0; g < NTAPS; g++) begin : g_taps
      assign o_fir_taps[g*TW +: TW] = taps_q[g];
   end

   assign o_s_ready      = state_q == StStream;
   assign o_fir_ce       = ce_q;
   assign o_fir_sample   = sample_q;
   assign o_fir_tap_wr   = state_q == StConfig;
   assign o_fir_ntaps_en = state_q == StConfig;
   assign o_fir_ntaps    = m_q;
   assign o_busy         = state_q != StIdle;
   assign o_done         = state_q == StDone;

endmodule

// File: tb/tb_fir_job_ctrl.sv
// Randomized bench for fir_job_ctrl; a fake filter answers each ce with a result strobe.
module tb_fir_job_ctrl;
   localparam int NTAPS = 8;
   localparam int IW    = 12;
   localparam int TW    = 12;
   localparam int LW    = 16;
   localparam int AW    = 3;

   logic                i_clk = 1'b0;
   logic                i_reset = 1'b1;
   logic                i_start = 1'b0, i_abort = 1'b0;
   logic [3:0]          i_ntaps = '0;
   logic [LW-1:0]       i_len = '0;
   logic                i_tap_we = 1'b0;
   logic [AW-1:0]       i_tap_addr = '0;
   logic [TW-1:0]       i_tap_wdata = '0;
   logic                i_s_valid = 1'b0;
   logic [IW-1:0]       i_s_data = '0;
   logic                i_fir_valid = 1'b0;
   logic                o_s_ready, o_fir_ce, o_fir_tap_wr, o_fir_ntaps_en;
   logic                o_busy, o_done, o_err;
   logic [IW-1:0]       o_fir_sample;
   logic [NTAPS*TW-1:0] o_fir_taps;
   logic [3:0]          o_fir_ntaps;

   fir_job_ctrl #(.NTAPS(NTAPS), .IW(IW), .TW(TW), .LW(LW), .AW(AW)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
      .i_ntaps(i_ntaps), .i_len(i_len), .i_tap_we(i_tap_we), .i_tap_addr(i_tap_addr),
      .i_tap_wdata(i_tap_wdata), .i_s_valid(i_s_valid), .i_s_data(i_s_data),
      .o_s_ready(o_s_ready), .o_fir_ce(o_fir_ce), .o_fir_sample(o_fir_sample),
      .o_fir_taps(o_fir_taps), .o_fir_tap_wr(o_fir_tap_wr), .o_fir_ntaps(o_fir_ntaps),
      .o_fir_ntaps_en(o_fir_ntaps_en), .i_fir_valid(i_fir_valid), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   logic [TW-1:0] tap_model [NTAPS];

   task automatic check(input string tag, input longint got, input longint exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int clamp_m(input int n);
      if (n == 0) return 1;
      if (n > NTAPS) return NTAPS;
      return n;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   task automatic check_taps(input string tag);
      logic [TW-1:0] t;
      for (int k = 0; k < NTAPS; k++) begin
         t = o_fir_taps[k*TW +: TW];
         check(tag, t, tap_model[k]);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_ready", o_s_ready, 0);
      check("rst_ce", o_fir_ce, 0);
      check("rst_sample", o_fir_sample, 0);
      check("rst_tap_wr", o_fir_tap_wr, 0);
      check("rst_ntaps", o_fir_ntaps, NTAPS);
      check("rst_ntaps_en", o_fir_ntaps_en, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_err", o_err, 0);
      check_taps("rst_taps");
   endtask

   // vmode: 0 valid always, 1 toggling, 2 random. max_str < 0: unlimited result strobes.
   task automatic run_job(input int ntaps, input int len, input int vmode, input int max_str,
                          input int abort_ce, input bit expect_hang, input bit start_wr);
      int m, sent, strobes, done_n, done_cyc, last_str, start_cyc, twr_n, abort_cyc, exp_res;
      bit pend, abort_now, aborted, exp_err, done_err;
      logic [IW-1:0] samp[$];
      logic [IW-1:0] exp_ce[$];
      logic [IW-1:0] got_ce[$];
      m = clamp_m(ntaps);
      sent = 0; strobes = 0; done_n = 0; done_cyc = 0; last_str = 0; twr_n = 0;
      abort_cyc = -100; pend = 0; abort_now = 0; aborted = 0; done_err = 0;
      exp_err = (max_str >= 0) && !expect_hang;
      for (int i = 0; i < len; i++) samp.push_back(IW'($urandom));
      exp_ce = samp;
      if (len > 0) for (int i = 0; i < m - 1; i++) exp_ce.push_back('0);
      exp_res = (len == 0) ? 0 : len + m - 1;

      i_start = 1'b1;
      i_ntaps = 4'(ntaps);
      i_len   = LW'(len);
      if (start_wr) begin
         i_tap_we    = 1'b1;
         i_tap_addr  = AW'($urandom);
         i_tap_wdata = TW'($urandom);
         tap_model[i_tap_addr] = i_tap_wdata;
      end
      start_cyc = cyc;
      tick();
      i_start  = 1'b0;
      i_tap_we = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         case (vmode)
            0:       i_s_valid = (sent < len);
            1:       i_s_valid = (sent < len) && (c % 2 == 1);
            default: i_s_valid = (sent < len) && ($urandom_range(0, 1) == 1);
         endcase
         i_s_data    = (sent < len) ? samp[sent] : IW'($urandom);
         i_fir_valid = pend && (max_str < 0 || strobes < max_str);
         i_abort     = abort_now;
         if (abort_now) abort_cyc = cyc;
         // Writes while busy must be dropped
         i_tap_we    = !aborted && ($urandom_range(0, 3) == 0);
         i_tap_addr  = AW'($urandom);
         i_tap_wdata = TW'($urandom);
         @(negedge i_clk);
         if (i_s_valid && o_s_ready) sent++;
         if (i_fir_valid) begin
            strobes++;
            last_str = cyc;
         end
         pend = o_fir_ce;
         if (o_fir_ce) got_ce.push_back(o_fir_sample);
         if (o_fir_tap_wr) begin
            twr_n++;
            check("cfg_ntaps", o_fir_ntaps, m);
            check("cfg_ntaps_en", o_fir_ntaps_en, 1);
            check("cfg_busy", o_busy, 1);
            check("cfg_err", o_err, 0);
            check_taps("cfg_taps");
         end
         if (o_done) begin
            done_n++;
            done_cyc = cyc;
            done_err = o_err;
         end
         if (cyc == abort_cyc + 1) begin
            check("abort_busy", o_busy, 0);
            check("abort_ce", o_fir_ce, 0);
         end
         abort_now = 0;
         if (abort_ce >= 0 && !aborted && got_ce.size() == abort_ce) begin
            abort_now = 1;
            aborted   = 1;
         end
         tick();
         if (done_n > 0) break;
         if (aborted && abort_cyc > 0 && cyc > abort_cyc + 20) break;
         if (expect_hang && c == 1100) break;
      end
      i_tap_we    = 1'b0;
      i_s_valid   = 1'b0;
      i_fir_valid = 1'b0;
      i_abort     = 1'b0;

      check("tap_wr_pulses", twr_n, 1);
      if (aborted) begin
         check("abort_no_done", done_n, 0);
      end else if (expect_hang) begin
         check("hang_busy", o_busy, 1);
         check("hang_err", o_err, 0);
         check("hang_no_done", done_n, 0);
         i_abort = 1'b1;
         tick();
         i_abort = 1'b0;
         check("hang_abort_busy", o_busy, 0);
      end else begin
         check("done_pulses", done_n, 1);
         check("done_err", done_err, exp_err);
         check("ce_count", got_ce.size(), exp_ce.size());
         for (int i = 0; i < exp_ce.size() && i < got_ce.size(); i++)
            check($sformatf("ce_data[%0d]", i), got_ce[i], exp_ce[i]);
         if (len == 0) begin
            check("l0_done_lat", done_cyc - start_cyc, 2);
         end else if (exp_err) begin
            check("timeout_lat", done_cyc - last_str, 1023);
         end else begin
            check("strobes", strobes, exp_res);
            check("done_lat", done_cyc - last_str, 1);
         end
      end
      tick();
      check("idle_busy", o_busy, 0);
      check_taps("post_taps");
   endtask

   initial begin
      for (int k = 0; k < NTAPS; k++) tap_model[k] = '0;
      #12;
      check_reset_outputs();
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      tick();

      for (int a = 0; a < NTAPS; a++) begin
         i_tap_we    = 1'b1;
         i_tap_addr  = AW'(a);
         i_tap_wdata = TW'(a + 1);
         tap_model[a] = TW'(a + 1);
         tick();
      end
      i_tap_we = 1'b0;

      run_job(8, 4, 0, -1, -1, 0, 0);
      run_job(5, 3, 1, -1, -1, 0, 1);
      run_job(0, 5, 2, -1, -1, 0, 1);
      run_job(12, 6, 0, -1, -1, 0, 1);
      run_job(5, 0, 0, -1, -1, 0, 1);
      run_job(8, 4, 0, -1, 5, 0, 0);
`ifdef FIR_JOB_CTRL_TIMEOUT_EN
      run_job(4, 2, 0, 3, -1, 0, 0);
`else
      run_job(4, 2, 0, 3, -1, 1, 0);
`endif
      for (int j = 0; j < 4; j++)
         run_job(int'($urandom_range(0, 15)), int'($urandom_range(1, 20)),
                 int'($urandom_range(0, 2)), -1, -1, 0, 1);

      // Asynchronous reset in the middle of a stream
      i_start = 1'b1;
      i_ntaps = 4'd3;
      i_len   = LW'(6);
      tick();
      i_start   = 1'b0;
      i_s_valid = 1'b1;
      i_s_data  = IW'(7);
      repeat (3) tick();
      check("pre_rst_ready", o_s_ready, 1);
      #2;
      i_reset = 1'b1;
      #1;
      for (int k = 0; k < NTAPS; k++) tap_model[k] = '0;
      check_reset_outputs();
      i_s_valid = 1'b0;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      tick();

      run_job(6, 7, 2, -1, -1, 0, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
